// File: rtl/smart_counter_pkg.sv
// ==========================================================================
// smart_counter_pkg : shared state encoding and prescaler limits for the
//                     SMARTCOUNTER timer cluster.            Rev 1.0
// ==========================================================================
`default_nettype none

package smart_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int PRESCALE_MIN   = 1;
   localparam int PRESCALE_MAX   = 256;
   localparam int PRESCALE_CNT_W = 8;

endpackage : smart_counter_pkg

`default_nettype wire

// File: rtl/smart_down_timer_if.sv
// ==========================================================================
// smart_down_timer_if : control/status bundle of the countdown timer.
//                                                             Rev 1.0
// ==========================================================================
`default_nettype none

interface smart_down_timer_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] data_in;
   logic             start;
   logic             stop;
   logic             enable;
   logic             auto_reload;
   logic             irq_clr;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             irq;

   modport master (
      output load, data_in, start, stop, enable, auto_reload, irq_clr,
      input  count, busy, done, irq
   );

   modport slave (
      input  load, data_in, start, stop, enable, auto_reload, irq_clr,
      output count, busy, done, irq
   );
endinterface : smart_down_timer_if

`default_nettype wire

// File: rtl/smart_prescaler.sv
// ==========================================================================
// smart_prescaler : divides enabled clock cycles by PRESCALE, one tick per
//                   wrap of the internal counter.              Rev 1.0
// ==========================================================================
`default_nettype none

module smart_prescaler
   import smart_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic enable,
   output logic tick
);

   // Out-of-range values are clamped so the counter width stays fixed.
   localparam int c_eff = (PRESCALE < PRESCALE_MIN) ? PRESCALE_MIN :
                          (PRESCALE > PRESCALE_MAX) ? PRESCALE_MAX : PRESCALE;
   localparam logic [PRESCALE_CNT_W-1:0] c_last = PRESCALE_CNT_W'(c_eff - 1);

   logic [PRESCALE_CNT_W-1:0] r_cnt;
   logic                      w_wrap;

   assign w_wrap = (r_cnt == c_last);
   assign tick   = enable && w_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= w_wrap ? '0 : r_cnt + PRESCALE_CNT_W'(1);
      end
   end

endmodule : smart_prescaler

`default_nettype wire

// File: rtl/smart_down_timer.sv
// ==========================================================================
// smart_down_timer : reloadable prescaled down-counter with done pulse,
//                    sticky irq and optional auto-reload.      Rev 1.0
// ==========================================================================
`default_nettype none

module smart_down_timer
   import smart_counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   smart_down_timer_if.slave bus
);

   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_count, w_count_nx;
   logic [WIDTH-1:0] r_reload, w_reload_nx;
   logic             r_done, w_done_nx;
   logic             r_irq, w_irq_nx;
   logic             r_busy;
   logic             w_presc_clr;
   logic             w_presc_en;
   logic             w_tick;

   assign w_presc_en = (r_state == RUN) && bus.enable;

   smart_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_presc_clr),
      .enable (w_presc_en),
      .tick   (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_done   <= 1'b0;
         r_irq    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_count  <= w_count_nx;
         r_reload <= w_reload_nx;
         r_done   <= w_done_nx;
         r_irq    <= w_irq_nx;
         r_busy   <= (w_state_nx == RUN);
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_count_nx  = r_count;
      w_reload_nx = r_reload;
      w_done_nx   = 1'b0;
      w_irq_nx    = r_irq && !bus.irq_clr;
      w_presc_clr = 1'b0;

      // Priority load > stop > start; a stop outside RUN still masks start.
      if (bus.load) begin
         w_reload_nx = bus.data_in;
         w_count_nx  = bus.data_in;
         w_presc_clr = 1'b1;
         w_state_nx  = IDLE;
      end else if (bus.stop) begin
         if (r_state == RUN) begin
            w_state_nx  = IDLE;
            w_presc_clr = 1'b1;
         end
      end else if (bus.start) begin
         w_presc_clr = 1'b1;
         if (r_state == RUN) begin
            w_count_nx = r_reload;
         end else if (r_reload != '0) begin
            w_count_nx = r_reload;
            w_state_nx = RUN;
         end else begin
            w_count_nx = '0;
            w_state_nx = DONE;
            w_done_nx  = 1'b1;
            w_irq_nx   = 1'b1;
         end
      end else begin
         case (r_state)
            RUN: begin
               if (w_tick) begin
                  if (r_count > c_one) begin
                     w_count_nx = r_count - c_one;
                  end else if (r_count == c_one) begin
                     w_done_nx = 1'b1;
                     w_irq_nx  = 1'b1;
                     if (bus.auto_reload) begin
                        w_count_nx = r_reload;
                     end else begin
                        w_count_nx = '0;
                        w_state_nx = DONE;
                     end
                  end
               end
            end
            DONE: begin
               w_count_nx = '0;
            end
            default: begin
               w_state_nx = r_state;
            end
         endcase
      end
   end

   assign bus.count = r_count;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.irq   = r_irq;

endmodule : smart_down_timer

`default_nettype wire

// File: tb/tb_smart_down_timer.sv
// ==========================================================================
// tb_smart_down_timer : directed scoreboard bench for smart_down_timer with
//                       PRESCALE=1 (dut_a) and PRESCALE=4 (dut_b). Rev 1.0
// ==========================================================================
`default_nettype none

module tb_smart_down_timer;

   typedef struct {
      logic [7:0] count;
      logic       busy;
      logic       done;
      logic       irq;
      string      tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   smart_down_timer_if #(.WIDTH(8)) ifa ();
   smart_down_timer_if #(.WIDTH(8)) ifb ();

   smart_down_timer #(.WIDTH(8), .PRESCALE(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   smart_down_timer #(.WIDTH(8), .PRESCALE(4)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string tag, logic [7:0] c, logic b, logic d, logic i,
                                 exp_t e);
      n_total++;
      if (c === e.count && b === e.busy && d === e.done && i === e.irq) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got count=%0h busy=%b done=%b irq=%b, expected count=%0h busy=%b done=%b irq=%b",
                  tag, c, b, d, i, e.count, e.busy, e.done, e.irq);
      end
   endfunction

   always @(posedge clk) begin
      #1;
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         check(ea.tag, ifa.count, ifa.busy, ifa.done, ifa.irq, ea);
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         check(eb.tag, ifb.count, ifb.busy, ifb.done, ifb.irq, eb);
      end
   end

   task automatic idle_inputs();
      ifa.load = 1'b0; ifa.data_in = 8'h00; ifa.start = 1'b0; ifa.stop = 1'b0;
      ifa.enable = 1'b0; ifa.auto_reload = 1'b0; ifa.irq_clr = 1'b0;
      ifb.load = 1'b0; ifb.data_in = 8'h00; ifb.start = 1'b0; ifb.stop = 1'b0;
      ifb.enable = 1'b0; ifb.auto_reload = 1'b0; ifb.irq_clr = 1'b0;
   endtask

   // Drive one cycle of stimulus on the selected DUT and queue the outputs
   // expected right after the following rising edge.
   task automatic step(input bit sel, input bit ld, input logic [7:0] din,
                       input bit st, input bit sp, input bit en, input bit ar,
                       input bit ic, input logic [7:0] ec, input bit eb_,
                       input bit ed, input bit ei, input string tag);
      exp_t e;
      @(negedge clk);
      idle_inputs();
      if (!sel) begin
         ifa.load = ld; ifa.data_in = din; ifa.start = st; ifa.stop = sp;
         ifa.enable = en; ifa.auto_reload = ar; ifa.irq_clr = ic;
      end else begin
         ifb.load = ld; ifb.data_in = din; ifb.start = st; ifb.stop = sp;
         ifb.enable = en; ifb.auto_reload = ar; ifb.irq_clr = ic;
      end
      e.count = ec; e.busy = eb_; e.done = ed; e.irq = ei; e.tag = tag;
      if (!sel) qa.push_back(e);
      else      qb.push_back(e);
      @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t z;
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      step(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "reset_a");
      step(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "reset_b");

      // One-shot, PRESCALE=1
      step(0, 1, 8'h03, 0, 0, 1, 0, 0, 8'h03, 0, 0, 0, "os_load");
      step(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h03, 1, 0, 0, "os_start");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h02, 1, 0, 0, "os_c2");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 1, 0, 0, "os_c1");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 1, "os_term");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1, "os_done_hold");

      // Asynchronous reset in the middle of a countdown
      step(0, 1, 8'h05, 0, 0, 1, 0, 0, 8'h05, 0, 0, 1, "rm_load");
      step(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h05, 1, 0, 1, "rm_start");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h04, 1, 0, 1, "rm_t1");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h03, 1, 0, 1, "rm_t2");
      #3 rst_n = 1'b0;
      #1;
      z.count = 8'h00; z.busy = 1'b0; z.done = 1'b0; z.irq = 1'b0; z.tag = "async_reset";
      check("async_reset", ifa.count, ifa.busy, ifa.done, ifa.irq, z);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;

      // Auto-reload periodic mode, irq set/clear collision, stop
      step(0, 1, 8'h02, 0, 0, 1, 1, 0, 8'h02, 0, 0, 0, "ar_load");
      step(0, 0, 8'h00, 1, 0, 1, 1, 0, 8'h02, 1, 0, 0, "ar_start");
      step(0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h01, 1, 0, 0, "ar_c1");
      step(0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h02, 1, 1, 1, "ar_wrap1");
      step(0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h01, 1, 0, 1, "ar_c1b");
      step(0, 0, 8'h00, 0, 0, 1, 1, 1, 8'h02, 1, 1, 1, "irqclr_vs_set");
      step(0, 0, 8'h00, 0, 0, 1, 1, 1, 8'h01, 1, 0, 0, "irq_clr");
      step(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h01, 0, 0, 0, "stop_hold");

      // Command priority
      step(0, 1, 8'h07, 1, 1, 1, 0, 0, 8'h07, 0, 0, 0, "prio_load");
      step(0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h07, 0, 0, 0, "prio_stop_idle");
      step(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h07, 1, 0, 0, "prio_start");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h06, 1, 0, 0, "prio_c6");
      step(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h07, 1, 0, 0, "restart");
      step(0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h07, 0, 0, 0, "stop_run");

      // Zero reload
      step(0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, "z_load");
      step(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 1, 1, "z_start");
      step(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1, "z_hold");
      step(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 1, 1, "z_restart");
      step(0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 0, 0, 0, "z_irqclr");

      // PRESCALE=4 with enable gaps
      step(1, 1, 8'h02, 0, 0, 1, 0, 0, 8'h02, 0, 0, 0, "ps_load");
      step(1, 0, 8'h00, 1, 0, 1, 0, 0, 8'h02, 1, 0, 0, "ps_start");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h02, 1, 0, 0, "ps_e1");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h02, 1, 0, 0, "ps_e2");
      step(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h02, 1, 0, 0, "ps_hold");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h02, 1, 0, 0, "ps_e3");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 1, 0, 0, "ps_dec");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 1, 0, 0, "ps_p1");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 1, 0, 0, "ps_p2");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h01, 1, 0, 0, "ps_p3");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 1, "ps_term");
      step(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1, "ps_after");

      @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_smart_down_timer

`default_nettype wire
